// File: rtl/encoder8_3_serial.sv
// Serial 8-to-3 priority encoder: emits the index of every set bit of an accepted word, one beat per bit.
// Define ENC_ERR_EN to add the err_o port and emit a single error beat for an all-zero word.
module encoder8_3_serial #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] in_word_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [2:0] out_idx_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_last_o,
  output logic [3:0] out_cnt_o
`ifdef ENC_ERR_EN
  ,
  output logic       err_o
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] idx_q, idx_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fire, accept, zero_beat;
`ifdef ENC_ERR_EN
  logic       err_q, err_d;
`endif

  function automatic logic [3:0] popcount(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + 4'(m[i]);
    return c;
  endfunction

  // Scan so the last hit found is the preferred end of the word.
  function automatic logic [2:0] pick(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    fire       = (state_q == BUSY) && out_ready_i;
    in_ready_o = (state_q == IDLE) || (fire && last_q);
    accept     = in_valid_i && in_ready_o;
    state_d    = state_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    zero_beat  = 1'b0;
`ifdef ENC_ERR_EN
    err_d      = err_q;
`endif
    if (fire) begin
      mask_d = mask_q & ~(8'b1 << idx_q);
      if (last_q) begin
        state_d = IDLE;
        mask_d  = 8'h00;
`ifdef ENC_ERR_EN
        err_d   = 1'b0;
`endif
      end
    end
    if (accept) begin
      mask_d = in_word_i;
      cnt_d  = popcount(in_word_i);
      if (in_word_i != 8'h00) begin
        state_d = BUSY;
      end
`ifdef ENC_ERR_EN
      else begin
        state_d   = BUSY;
        zero_beat = 1'b1;
      end
      err_d = zero_beat;
`endif
    end
    // Index and last flag are precomputed from the next mask so the outputs come straight from flops.
    if (fire || accept) begin
      idx_d  = pick(mask_d);
      last_d = (popcount(mask_d) == 4'd1) || zero_beat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= 8'h00;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      cnt_q   <= 4'd0;
`ifdef ENC_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef ENC_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out_valid_o = (state_q == BUSY);
  assign out_idx_o   = idx_q;
  assign out_last_o  = last_q;
  assign out_cnt_o   = cnt_q;
`ifdef ENC_ERR_EN
  assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_encoder8_3_serial.sv
// Scoreboard bench: drives an LSB-first and an MSB-first instance in lockstep and checks both against a word-level model.
module tb_encoder8_3_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_word;
  logic       in_valid, out_ready;
  logic [1:0] in_ready, out_valid, out_last, err;
  logic [2:0] out_idx [2];
  logic [3:0] out_cnt [2];

  always #5 clk = ~clk;

  encoder8_3_serial #(.LSB_FIRST(1'b1)) dut_l (
    .clk_i(clk), .rst_ni(rst_n), .in_word_i(in_word), .in_valid_i(in_valid),
    .in_ready_o(in_ready[0]), .out_idx_o(out_idx[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready), .out_last_o(out_last[0]), .out_cnt_o(out_cnt[0])
`ifdef ENC_ERR_EN
    , .err_o(err[0])
`endif
  );

  encoder8_3_serial #(.LSB_FIRST(1'b0)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .in_word_i(in_word), .in_valid_i(in_valid),
    .in_ready_o(in_ready[1]), .out_idx_o(out_idx[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready), .out_last_o(out_last[1]), .out_cnt_o(out_cnt[1])
`ifdef ENC_ERR_EN
    , .err_o(err[1])
`endif
  );

`ifndef ENC_ERR_EN
  assign err = 2'b00;
`endif

  typedef struct packed {
    logic [2:0] idx_l;
    logic [2:0] idx_m;
    logic       last;
    logic [3:0] cnt;
    logic       err;
  } beat_t;

  beat_t      exp_q[$];
  logic [3:0] cnt_exp;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list set-bit positions in ascending and descending order.
  task automatic push_word(input logic [7:0] w);
    int lo[$];
    int hi[$];
    beat_t b;
    for (int i = 0; i < 8; i++) if (w[i]) lo.push_back(i);
    for (int i = 7; i >= 0; i--) if (w[i]) hi.push_back(i);
    for (int k = 0; k < lo.size(); k++) begin
      b.idx_l = 3'(lo[k]);
      b.idx_m = 3'(hi[k]);
      b.last  = (k == lo.size() - 1);
      b.cnt   = 4'(lo.size());
      b.err   = 1'b0;
      exp_q.push_back(b);
    end
`ifdef ENC_ERR_EN
    if (w == 8'h00) begin
      b = '{idx_l: 3'd0, idx_m: 3'd0, last: 1'b1, cnt: 4'd0, err: 1'b1};
      exp_q.push_back(b);
    end
`endif
  endtask

  // Monitor: one line per consumed beat, checks every cycle.
  always @(negedge clk) begin
    logic  exp_rdy;
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      cnt_exp = 4'd0;
      chk("reset_outputs",
          32'({out_valid, out_last, out_idx[0], out_idx[1], out_cnt[0], out_cnt[1], err}), 32'd0);
    end else begin
      exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q[0].last);
      chk("in_ready", 32'(in_ready), exp_rdy ? 32'd3 : 32'd0);
      chk("out_cnt", 32'({out_cnt[0], out_cnt[1]}), 32'({cnt_exp, cnt_exp}));
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("beat_lsb", 32'({out_valid[0], out_idx[0], out_last[0], out_cnt[0], err[0]}),
            32'({1'b1, e.idx_l, e.last, e.cnt, e.err}));
        chk("beat_msb", 32'({out_valid[1], out_idx[1], out_last[1], out_cnt[1], err[1]}),
            32'({1'b1, e.idx_m, e.last, e.cnt, e.err}));
        if (out_ready) begin
          $display("beat idx_l=%0d idx_m=%0d last=%0d cnt=%0d err=%0d",
                   out_idx[0], out_idx[1], out_last[0], out_cnt[0], err[0]);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("no_beat", 32'(out_valid), 32'd0);
      end
      if (in_valid && exp_rdy) begin
        $display("accept word=%02h", in_word);
        push_word(in_word);
        cnt_exp = 4'($countones(in_word));
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] w, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_word   = w;
    out_ready = r;
  endtask

  task automatic send(input logic [7:0] w, input logic r);
    int  n;
    logic acc;
    n = 0;
    do begin
      step(1'b1, w, r);
      #1;
      acc = in_ready[0];
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got=in_ready 0 want=1 word=%02h", w);
    end
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step(1'b0, 8'($urandom), r);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_word = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b1);

    send(8'h04, 1'b1); idle(3, 1'b1);
    send(8'hA5, 1'b1); idle(6, 1'b1);
    send(8'h81, 1'b0); idle(3, 1'b0); idle(4, 1'b1);
    send(8'h03, 1'b1); send(8'h40, 1'b1); idle(3, 1'b1);
    send(8'h00, 1'b1); idle(3, 1'b1);

    send(8'hFF, 1'b1); idle(2, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 32'({out_valid, out_last}), 32'd0);
    idle(2, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6, 1'b1);

    repeat (400) begin
      logic [7:0] w;
      case ($urandom % 4)
        0: w = 8'h00;
        1: w = 8'b1 << ($urandom % 8);
        default: w = 8'($urandom);
      endcase
      step(($urandom % 2) == 0, w, ($urandom % 4) != 0);
    end

    step(1'b0, 8'h00, 1'b1);
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder8_3_serial.md
ENCODER8_3_SERIAL -- requirements
Module: encoder8_3_serial

Interface
REQ-001 Parameter: LSB_FIRST, default 1, scan order: 1 = bit 0 first, 0 = bit 7 first.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_word  input  8  multi-hot word to encode.
REQ-005 in_valid  input  1  in_word valid.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_idx  output  3  binary index of the current set bit.
REQ-008 out_valid  output  1  out_idx valid.
REQ-009 out_ready  input  1  consumer accepts the current beat.
REQ-010 out_last  output  1  current beat is the final beat for the word.
REQ-011 out_cnt  output  4  popcount of the word being emitted, range 0..8.
REQ-012 err  output  1  zero-word indication; port exists only with ENC_ERR_EN.

Function
REQ-013 The block SHALL emit the index of every set bit in an accepted word, one beat per bit, as the inverse of the 3-to-8 decoder.
- FSM has two states, IDLE and BUSY.
- In IDLE, in_ready=1 and out_valid=0.
- In BUSY, out_valid=1.
REQ-014 Accept occurs on in_valid&&in_ready.
- The block SHALL register in_word into a pending mask and popcount(in_word) into out_cnt.
- If in_word is nonzero, the FSM SHALL go to BUSY.
REQ-015 Latency: the first out_valid SHALL appear in the cycle after accept, and all outputs SHALL be registered.
REQ-016 out_idx SHALL be the lowest set bit of the pending mask when LSB_FIRST=1, and the highest set bit when LSB_FIRST=0.
REQ-017 out_last SHALL be 1 exactly when the pending mask has one bit set.
REQ-018 On out_valid&&out_ready, the block SHALL clear the emitted bit from the mask.
- If out_last=1, the FSM SHALL go to IDLE.
- Otherwise the next beat SHALL follow in the next cycle, with no bubble.
REQ-019 Backpressure: while out_valid=1 and out_ready=0, out_idx, out_last, out_cnt and the mask SHALL hold stable.
REQ-020 in_ready SHALL be 1 in IDLE, and also in BUSY during a cycle where out_valid&&out_ready&&out_last.
- An accept in that cycle loads the new word, and its first beat follows next cycle with no bubble.
REQ-021 in_ready SHALL be 0 in all other BUSY cycles, and in_word SHALL be ignored during them.
REQ-022 A zero word SHALL be handled per REQ-027/REQ-028.
REQ-023 out_cnt SHALL hold its value until the next accept.

Reset
REQ-024 While rst=0, the block SHALL force the following, asynchronously:
- FSM=IDLE, mask=0;
- out_valid=0, out_idx=0, out_last=0, out_cnt=0, err=0;
- in_ready=1 once rst is released.
REQ-025 Reset asserted mid-word SHALL discard the remaining beats; no beat of that word SHALL appear after release.

Configuration
REQ-026 Macro ENC_ERR_EN SHALL compile zero-word error reporting in or out.
REQ-027 With ENC_ERR_EN defined, accepting in_word=0 SHALL produce exactly one beat next cycle.
- The beat carries out_idx=0, out_last=1, out_cnt=0, err=1, with the normal handshake.
- err SHALL be 0 on all other beats.
REQ-028 With ENC_ERR_EN undefined, the err port SHALL be absent.
- in_word=0 SHALL still be accepted, then dropped.
- The FSM SHALL stay in IDLE, in_ready SHALL stay 1, out_valid SHALL stay 0, and out_cnt SHALL update to 0.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Single bit: LSB_FIRST=1, in_word=8'h04, out_ready=1 -> one beat next cycle: idx=2, last=1, cnt=1.
- Multi-bit: in_word=8'hA5, out_ready=1.
  - LSB_FIRST=1 -> idx 0,2,5,7 on 4 consecutive cycles, last only on 7, cnt=4.
  - LSB_FIRST=0 -> idx 7,5,2,0.
- Backpressure: in_word=8'h81, out_ready=0 for 3 cycles -> idx=0 held stable, then idx 0,7 once out_ready=1.
- Back-to-back: in_word=8'h03 then 8'h40, with in_valid high on the last-beat cycle -> idx 0,1,6 on consecutive cycles, no bubble.
- Reset mid-burst: in_word=8'hFF, rst=0 after 2 beats -> out_valid=0 immediately; after release, in_ready=1 and no further beats.
- Zero word, in_word=8'h00:
  - ENC_ERR_EN defined -> one beat idx=0, last=1, err=1.
  - ENC_ERR_EN undefined -> no beat, in_ready stays 1.
